dense_sched: RTL and testbench

Sequencer and arbiter for the shared dense-layer multiply-accumulate datapath. Three layer requesters compete for one MAC unit and one shared weight/bias ROM:
- layer 0: input dense, 42→24
- layer 1: VAD output, 24→1
- layer 2: denoise output, 96→22

The block grants one requester at a time and walks the granted layer neuron-by-neuron. It issues weight, bias and input addresses, drives MAC strobes aligned to one-cycle ROM read latency, and hands each finished neuron to the activation stage through a valid/ready handshake.

---
 rtl/dense_sched_if.sv | 25 ++
 rtl/dense_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_dense_sched.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dense_sched_if.sv
// dense_sched_if: request/grant, ROM address, MAC strobe and output handshake
// signals between the dense-layer scheduler and the surrounding datapath.
interface dense_sched_if;
    logic [2:0]  req;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [11:0] w_addr;
    logic [5:0]  b_addr;
    logic [6:0]  in_idx;
    logic        mac_clr;
    logic        mac_en;
    logic        out_valid;
    logic [6:0]  out_idx;
    logic        out_ready;

    modport master (
        input  req, out_ready,
        output gnt, done, w_addr, b_addr, in_idx, mac_clr, mac_en, out_valid, out_idx
    );

    modport slave (
        output req, out_ready,
        input  gnt, done, w_addr, b_addr, in_idx, mac_clr, mac_en, out_valid, out_idx
    );
endinterface

// File: rtl/dense_sched.sv
// dense_sched: arbiter and neuron sequencer for the shared dense-layer MAC.
// Grants one of three layer requesters, walks its neurons issuing bias, weight
// and input addresses aligned to a one-cycle ROM read, and hands each finished
// neuron to the activation stage over a valid/ready handshake.
// Build option: define DENSE_SCHED_RR_EN for round-robin arbitration; without
// it arbitration is fixed priority req[0] > req[1] > req[2].
module dense_sched #(
    parameter int MAC_LAT  = 2,
    parameter int L0_NIN   = 42,
    parameter int L0_NOUT  = 24,
    parameter int L1_NIN   = 24,
    parameter int L1_NOUT  = 1,
    parameter int L2_NIN   = 96,
    parameter int L2_NOUT  = 22,
    parameter int L0_WBASE = 0,
    parameter int L1_WBASE = 1008,
    parameter int L2_WBASE = 1032,
    parameter int L0_BBASE = 0,
    parameter int L1_BBASE = 24,
    parameter int L2_BBASE = 25
) (
    input logic           clk,
    input logic           rst,
    dense_sched_if.master bus
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_EMIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  lay_q, lay_d;
    logic [6:0]  i_q, i_d;
    logic [6:0]  j_q, j_d;
    logic [3:0]  d_q, d_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [2:0]  done_q, done_d;
    logic [11:0] w_addr_q, w_addr_d;
    logic [5:0]  b_addr_q, b_addr_d;
    logic [6:0]  in_idx_q, in_idx_d;
    logic        mac_clr_q, mac_clr_d;
    logic        mac_en_q, mac_en_d;
    logic        out_valid_q, out_valid_d;
    logic [6:0]  out_idx_q, out_idx_d;
    logic [1:0]  win;

    function automatic logic [6:0] nin_of(input logic [1:0] l);
        case (l)
            2'd0:    return 7'(L0_NIN);
            2'd1:    return 7'(L1_NIN);
            default: return 7'(L2_NIN);
        endcase
    endfunction

    function automatic logic [6:0] nout_of(input logic [1:0] l);
        case (l)
            2'd0:    return 7'(L0_NOUT);
            2'd1:    return 7'(L1_NOUT);
            default: return 7'(L2_NOUT);
        endcase
    endfunction

    function automatic logic [11:0] wbase_of(input logic [1:0] l);
        case (l)
            2'd0:    return 12'(L0_WBASE);
            2'd1:    return 12'(L1_WBASE);
            default: return 12'(L2_WBASE);
        endcase
    endfunction

    function automatic logic [5:0] bbase_of(input logic [1:0] l);
        case (l)
            2'd0:    return 6'(L0_BBASE);
            2'd1:    return 6'(L1_BBASE);
            default: return 6'(L2_BBASE);
        endcase
    endfunction

`ifdef DENSE_SCHED_RR_EN
    logic [1:0] ptr_q, ptr_d;

    // First requester found scanning upward from the pointer, wrapping 2 -> 0.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] rot;
        logic [1:0] off;
        logic [2:0] s;
        case (p)
            2'd1:    rot = {r[0], r[2], r[1]};
            2'd2:    rot = {r[1], r[0], r[2]};
            default: rot = r;
        endcase
        off = rot[0] ? 2'd0 : (rot[1] ? 2'd1 : 2'd2);
        s   = {1'b0, p} + {1'b0, off};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    assign win = rr_pick(bus.req, ptr_q);

    // Pointer moves to the layer after each newly granted one.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_IDLE && (|bus.req)) ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 2'd0;
        else     ptr_q <= ptr_d;
    end
`else
    assign win = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
`endif

    // Next state and registered outputs; addresses hold outside their phase.
    always_comb begin
        state_d     = state_q;
        lay_d       = lay_q;
        i_d         = i_q;
        j_d         = j_q;
        d_d         = d_q;
        gnt_d       = gnt_q;
        done_d      = 3'd0;
        w_addr_d    = w_addr_q;
        b_addr_d    = b_addr_q;
        in_idx_d    = in_idx_q;
        mac_clr_d   = 1'b0;
        mac_en_d    = 1'b0;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    lay_d    = win;
                    gnt_d    = 3'b001 << win;
                    i_d      = 7'd0;
                    b_addr_d = bbase_of(win);
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                // Bias word arrives next cycle, together with the clear strobe.
                mac_clr_d = 1'b1;
                j_d       = 7'd0;
                w_addr_d  = wbase_of(lay_q) + {5'd0, i_q};
                in_idx_d  = 7'd0;
                state_d   = S_MAC;
            end
            S_MAC: begin
                // Accumulate strobe trails the address by the ROM read latency.
                mac_en_d = 1'b1;
                if (j_q == nin_of(lay_q) - 7'd1) begin
                    d_d     = 4'd0;
                    state_d = S_DRAIN;
                end else begin
                    j_d      = j_q + 7'd1;
                    w_addr_d = w_addr_q + {5'd0, nout_of(lay_q)};
                    in_idx_d = j_q + 7'd1;
                end
            end
            S_DRAIN: begin
                if (d_q == 4'(MAC_LAT)) begin
                    out_valid_d = 1'b1;
                    out_idx_d   = i_q;
                    state_d     = S_EMIT;
                end else begin
                    d_d = d_q + 4'd1;
                end
            end
            S_EMIT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (i_q == nout_of(lay_q) - 7'd1) begin
                        done_d  = gnt_q;
                        gnt_d   = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        i_d      = i_q + 7'd1;
                        b_addr_d = bbase_of(lay_q) + 6'(i_q + 7'd1);
                        state_d  = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lay_q       <= 2'd0;
            i_q         <= 7'd0;
            j_q         <= 7'd0;
            d_q         <= 4'd0;
            gnt_q       <= 3'd0;
            done_q      <= 3'd0;
            w_addr_q    <= 12'd0;
            b_addr_q    <= 6'd0;
            in_idx_q    <= 7'd0;
            mac_clr_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 7'd0;
        end else begin
            state_q     <= state_d;
            lay_q       <= lay_d;
            i_q         <= i_d;
            j_q         <= j_d;
            d_q         <= d_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            w_addr_q    <= w_addr_d;
            b_addr_q    <= b_addr_d;
            in_idx_q    <= in_idx_d;
            mac_clr_q   <= mac_clr_d;
            mac_en_q    <= mac_en_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.b_addr    = b_addr_q;
    assign bus.in_idx    = in_idx_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_dense_sched.sv
// tb_dense_sched: randomized bench for dense_sched. Layer walks are checked
// against address/timing rules computed arithmetically from the layer geometry,
// and grants against a first-set-bit arbitration model.
module tb_dense_sched;
    localparam int MAC_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dense_sched_if bus();

    dense_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [2:0] req_r;
    int         ptr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int nin_of(input int k);
        case (k) 0: return 42; 1: return 24; default: return 96; endcase
    endfunction
    function automatic int nout_of(input int k);
        case (k) 0: return 24; 1: return 1; default: return 22; endcase
    endfunction
    function automatic int wbase_of(input int k);
        case (k) 0: return 0; 1: return 1008; default: return 1032; endcase
    endfunction
    function automatic int bbase_of(input int k);
        case (k) 0: return 0; 1: return 24; default: return 25; endcase
    endfunction

    // Winner = first requesting layer, scanning from the pointer (or from 0).
    function automatic int pick(input logic [2:0] r, input int p);
        int idx;
        for (int n = 0; n < 3; n++) begin
`ifdef DENSE_SCHED_RR_EN
            idx = (p + n) % 3;
`else
            idx = n;
`endif
            if (((r >> idx) & 3'b001) != 3'b000) return idx;
        end
        return 0;
    endfunction

    task automatic set_req(input logic [2:0] r);
        req_r   = r;
        bus.req = r;
    endtask

    // mode: 0 drop granted bit at done, 1 keep req, 2 drop all at done.
    task automatic serve_one(input int mode, input int bp, input bit force_stall,
                             input int abort_n, input bit early_drop);
        int w, k, lat, i, j, cyc, lay, stalls, held;
        bit fin, rdy;
        logic [11:0] pw;
        logic [6:0]  pin;
        logic [5:0]  pb;
        logic [31:0] frz;
        w   = pick(req_r, ptr);
        lat = 0;
        do begin
            @(posedge clk); @(negedge clk); lat++;
        end while (bus.gnt == 3'd0 && lat < 8);
        check_val("gnt_lat", lat, 1);
        check_val("gnt", bus.gnt, 3'b001 << w);
        if (bus.gnt == 3'd0) return;
        ptr = (w + 1) % 3;
        k = w;
        i = 0; j = 0; cyc = 0; lay = 0; stalls = 0; held = 0; fin = 0;
        pw = '0; pin = '0; pb = '0; frz = '0;
        while (!fin && lay < 30000) begin
            if (abort_n >= 0 && i == abort_n && j == 10) begin
                rst = 1'b1;
                #1;
                check_val("rst_async", {bus.gnt, bus.done, bus.w_addr, bus.b_addr, bus.in_idx,
                          bus.mac_clr, bus.mac_en, bus.out_valid, bus.out_idx}, 0);
                set_req(3'b000);
                ptr = 0;
                @(posedge clk); @(negedge clk);
                rst = 1'b0;
                repeat (4) begin
                    @(posedge clk); @(negedge clk);
                    check_val("no_done_after_rst", {bus.done, bus.gnt}, 0);
                end
                return;
            end
            if (early_drop && lay == 3) set_req(req_r & ~(3'b001 << k));
            if (cyc == 0) begin
                check_val("gnt_hold", bus.gnt, 3'b001 << k);
                check_val("valid_drop", bus.out_valid, 0);
            end
            if (bus.mac_clr || bus.mac_en)
                check_val("clr_en_excl", bus.mac_clr & bus.mac_en, 0);
            if (bus.mac_clr) begin
                check_val("clr_cyc", cyc, 1);
                check_val("b_addr", pb, bbase_of(k) + i);
            end
            if (bus.mac_en) begin
                check_val("w_addr", pw, wbase_of(k) + j * nout_of(k) + i);
                check_val("in_idx", pin, j);
                j++;
            end
            if (bus.out_valid) begin
                if (held == 0) begin
                    check_val("emit_cyc", cyc, nin_of(k) + MAC_LAT + 2);
                    check_val("mac_cnt", j, nin_of(k));
                    check_val("out_idx", bus.out_idx, i);
                    check_val("done_quiet", bus.done, 0);
                    frz = {bus.w_addr, bus.b_addr, bus.in_idx, bus.out_idx};
                end else begin
                    check_val("stall_frozen", {bus.w_addr, bus.b_addr, bus.in_idx, bus.out_idx}, frz);
                end
                if (force_stall && i == 1) rdy = (held >= 5);
                else                       rdy = ($urandom_range(0, 99) >= bp);
                bus.out_ready = rdy;
                if (!rdy) begin
                    held++; stalls++;
                end else if (i == nout_of(k) - 1) begin
                    if (k == 2) check_val("l2_last_w", bus.w_addr, 3143);
                    fin = 1;
                end else begin
                    i++; j = 0; held = 0; cyc = -1;
                end
            end else begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            pw = bus.w_addr; pin = bus.in_idx; pb = bus.b_addr;
            cyc++; lay++;
            @(posedge clk); @(negedge clk);
        end
        check_val("layer_finished", fin, 1);
        check_val("done", bus.done, 3'b001 << k);
        check_val("gnt_clear", bus.gnt, 0);
        check_val("idle_strobes", {bus.mac_clr, bus.mac_en, bus.out_valid}, 0);
        check_val("layer_len", lay, nout_of(k) * (nin_of(k) + MAC_LAT + 3) + stalls);
        if (mode == 0)      set_req(req_r & ~(3'b001 << k));
        else if (mode == 2) set_req(3'b000);
    endtask

    initial begin
        int r;
        rst = 1'b1; bus.req = 3'b000; bus.out_ready = 1'b1; req_r = 3'b000; ptr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_state", {bus.gnt, bus.done, bus.w_addr, bus.b_addr, bus.in_idx,
                  bus.mac_clr, bus.mac_en, bus.out_valid, bus.out_idx}, 0);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check_val("idle_no_req", {bus.gnt, bus.done, bus.mac_clr, bus.mac_en, bus.out_valid}, 0);

        // Layer 1 alone, no backpressure.
        set_req(3'b010);
        serve_one(0, 0, 0, -1, 0);
        // Layer 0 with a forced 5-cycle stall on neuron 1 plus random stalls.
        set_req(3'b001);
        serve_one(0, 20, 1, -1, 0);
        // All three at once.
        set_req(3'b111);
        repeat (3) serve_one(0, 10, 0, -1, 0);
        @(posedge clk); @(negedge clk);
        check_val("post_idle", {bus.gnt, bus.done, bus.mac_clr, bus.mac_en, bus.out_valid}, 0);
        // Layers 0 and 2 held high across three grants.
        set_req(3'b101);
        serve_one(1, 5, 0, -1, 0);
        serve_one(1, 5, 0, -1, 0);
        serve_one(2, 5, 0, -1, 0);
        // Reset mid-MAC on layer 2 neuron 5, then a clean re-run.
        @(posedge clk); @(negedge clk);
        set_req(3'b100);
        serve_one(0, 0, 0, 5, 0);
        set_req(3'b100);
        serve_one(0, 15, 0, -1, 0);
        @(posedge clk); @(negedge clk);
        check_val("final_idle", {bus.gnt, bus.done, bus.mac_clr, bus.mac_en, bus.out_valid}, 0);
        // Random request patterns, random backpressure, occasional early req drop.
        for (int it = 0; it < 4; it++) begin
            r = $urandom_range(1, 7);
            set_req(3'(r));
            for (int g = 0; g < 3 && req_r != 3'b000; g++)
                serve_one(0, $urandom_range(0, 40), 0, -1, 1'($urandom_range(0, 1)));
            @(posedge clk); @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
